pong_game_engine: RTL and testbench
===================================

# pong_game_engine

Game-state producer for the Pong display path. Advances ball and paddle positions once per video frame, detects wall, paddle and goal events, and keeps both scores. Drives the `ballx`, `bally`, `l_pos`, `r_pos`, `score_l` and `score_r` inputs of the 640x480 VGA renderer in the renderer's raw counter coordinates, where hc includes hbp = 144 and vc includes vbp = 31.

## Interface
- `FRAME_CYCLES`, 416800: dclk cycles per frame tick (800 x 521).
- `BALL_SPEED`, 2: ball pixels per frame on each axis.
- `PAD_SPEED`, 4: paddle pixels per frame.
- `SERVE_FRAMES`, 60: pause length before each serve.
- `WIN_SCORE`, 9: points needed to win, legal range 1..9.

Ports (clock and reset first):
- `dclk`  in  1  pixel clock, 25 MHz.
- `clr`  in  1  reset; asynchronous, active-high.
- `l_up`, `l_dn`, `r_up`, `r_dn`  in  1 each  paddle buttons; asynchronous, level.
- `start`  in  1  start button; asynchronous, level.
- `ballx`  out  10  ball centre, hc space.
- `bally`  out  10  ball centre, vc space.
- `l_pos`, `r_pos`  out  10 each  paddle top row, vc space.
- `score_l`, `score_r`  out  7 each  7-segment patterns, active-high; bit order a b c d e f g = [0]..[6].

## Operation
- All buttons pass through a 2-flop synchronizer. `start` is then rising-edge detected.
- Frame counter runs 0..FRAME_CYCLES-1. `tick` asserts when the count is 0.
- Ball footprint is x ballx-4..ballx+5 and y bally-4..bally+5.
- Geometry constants: Y_MIN 85, Y_MAX 455, PAD_MIN 81, PAD_MAX 361, LPAD_X 218, RPAD_X 713, GOAL_L 198, GOAL_R 729, centre (464, 271).
- Paddles move only on `tick`, in every state except IDLE and OVER.
  - up held: pos -= PAD_SPEED; dn held: pos += PAD_SPEED; both held or neither held: hold.
  - Result clamps to [PAD_MIN, PAD_MAX].
- FSM states: IDLE, SERVE, PLAY, POINT, OVER.
  - IDLE: ball at centre, scores 0. A start edge sets dx = +1, dy = +1 and moves to SERVE.
  - SERVE: counts SERVE_FRAMES ticks, then moves to PLAY. The ball is held at centre.
  - PLAY, on each tick, in this order:
    1. Compute nx = ballx ± BALL_SPEED and ny = bally ± BALL_SPEED.
    2. Vertical: if ny ≤ Y_MIN, set ny = Y_MIN and dy = +1. If ny ≥ Y_MAX, set ny = Y_MAX and dy = -1.
    3. Left paddle: if dx = -1, nx ≤ LPAD_X and (ny+5 ≥ l_pos and ny-4 ≤ l_pos+99), set nx = LPAD_X and dx = +1.
    4. Right paddle: mirror of step 3 with RPAD_X and r_pos, setting dx = -1.
    5. Goals: if nx ≤ GOAL_L the right player scores. If nx ≥ GOAL_R the left player scores. The scoring player's counter increments, and the state moves to POINT.
    6. A goal overrides any vertical bounce in the same tick.
  - POINT: ball to centre; dx points toward the player who conceded; dy inverts.
    - If the incremented score equals WIN_SCORE, go to OVER on the next cycle.
    - Otherwise go to SERVE on the next cycle.
  - OVER: ball at centre, scores frozen. A start edge clears scores, sets paddles to 221, and moves to SERVE.
- Score counters are 4-bit BCD, 0..9.
- The segment outputs are registered decodes of the counters: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- Arithmetic is 11-bit signed internally, so that nx going below 0 cannot wrap. Outputs are 10-bit unsigned.

## Timing
- Reset values:
  - `ballx` 464, `bally` 271.
  - `l_pos` and `r_pos` 221.
  - `score_l` and `score_r` 7'h3F.
  - State IDLE, frame counter 0, dx = +1, dy = +1.
- Position outputs change only on the cycle after `tick`. The tick coincides with renderer hc = 0, vc = 0, which lies in vertical blanking, so frames never tear.
- Segment outputs lag their counter by 1 cycle.
- Button latency: 2 sync cycles, plus a wait until the next tick.
- A start edge arriving in the same cycle as `tick` is honoured. The state transition takes precedence, and movement begins on the following tick.
- `clr` asserted mid-game returns everything to its reset values immediately.

## Structure
- Package `pong_pkg` holds:
  - the geometry constants;
  - the FSM state enum;
  - the function `seg7_decode(logic [3:0])`.
- The renderer's geometry should be moved into the same package.
- Sub-module `pong_paddle`, instantiated twice, contains the synchronizers, the up/down logic and the clamp.

## Test plan
- Reset, then run 3 frames with no input → outputs hold 464/271/221/221/3F/3F.
- Start, then 60 ticks → PLAY. Two ticks later `ballx` = 468 and `bally` = 275.
- Ball at y 456 heading down → bally = 455, and dy flips on the same tick.
- Ball at x 220 heading left with l_pos = 200 → ballx = 218, dx = +1. The same ball with l_pos = 361 → continues to GOAL_L, `score_r` = 06, state POINT then SERVE.
- `l_up` held for 100 ticks from 221 → l_pos clamps at 81. Both buttons held → no movement.
- WIN_SCORE = 2: left player scores twice → `score_l` = 5B, state OVER, ball frozen at centre. Start → both scores 3F and a new serve.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: renderer raw-counter timing, playfield geometry,
// game FSM encoding, debug view and the 7-segment digit decode.
package pong_pkg;
    // Renderer timing, raw counter space (hc includes hbp, vc includes vbp)
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 521;
    localparam int HBP     = 144;
    localparam int HFP     = 784;
    localparam int VBP     = 31;
    localparam int VFP     = 511;

    typedef logic signed [10:0] coord_t;

    localparam coord_t Y_MIN     = 11'sd85;
    localparam coord_t Y_MAX     = 11'sd455;
    localparam coord_t PAD_MIN   = 11'sd81;
    localparam coord_t PAD_MAX   = 11'sd361;
    localparam coord_t PAD_SPAN  = 11'sd99;
    localparam coord_t PAD_RESET = 11'sd221;
    localparam coord_t LPAD_X    = 11'sd218;
    localparam coord_t RPAD_X    = 11'sd713;
    localparam coord_t GOAL_L    = 11'sd198;
    localparam coord_t GOAL_R    = 11'sd729;
    localparam coord_t CENTRE_X  = 11'sd464;
    localparam coord_t CENTRE_Y  = 11'sd271;
    localparam coord_t BALL_TOP  = 11'sd4;
    localparam coord_t BALL_BOT  = 11'sd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_t;

    // Direction bits: 1 = moving toward larger coordinates
    typedef struct packed {
        state_t state;
        logic   dx_pos;
        logic   dy_pos;
    } dbg_t;

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg7_decode = 7'h3F;
            4'd1:    seg7_decode = 7'h06;
            4'd2:    seg7_decode = 7'h5B;
            4'd3:    seg7_decode = 7'h4F;
            4'd4:    seg7_decode = 7'h66;
            4'd5:    seg7_decode = 7'h6D;
            4'd6:    seg7_decode = 7'h7D;
            4'd7:    seg7_decode = 7'h07;
            4'd8:    seg7_decode = 7'h7F;
            4'd9:    seg7_decode = 7'h6F;
            default: seg7_decode = 7'h00;
        endcase
    endfunction
endpackage

// File: rtl/pong_paddle.sv
// One paddle: button synchronizers, up/down step on the frame tick, clamp to
// the legal travel range, and a reload to the rest row for a new game.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PAD_SPEED = 4
) (
    input  logic       i_dclk,
    input  logic       i_clr,
    input  logic       i_up,
    input  logic       i_dn,
    input  logic       i_tick,
    input  logic       i_en,
    input  logic       i_load,
    output logic [9:0] o_pos
);
    localparam coord_t     STEP    = coord_t'(PAD_SPEED);
    localparam logic [9:0] POS_MIN = PAD_MIN[9:0];
    localparam logic [9:0] POS_MAX = PAD_MAX[9:0];
    localparam logic [9:0] POS_RST = PAD_RESET[9:0];

    logic [1:0] r_up_sync;
    logic [1:0] r_dn_sync;
    logic [9:0] r_pos;
    coord_t     w_sum;
    logic [9:0] w_next;

    always_comb begin
        w_sum = coord_t'({1'b0, r_pos});
        if (r_up_sync[1] && !r_dn_sync[1])
            w_sum = w_sum - STEP;
        else if (r_dn_sync[1] && !r_up_sync[1])
            w_sum = w_sum + STEP;
        // Signed compare so an underflowing step still clamps to the top
        if (w_sum < PAD_MIN)
            w_next = POS_MIN;
        else if (w_sum > PAD_MAX)
            w_next = POS_MAX;
        else
            w_next = w_sum[9:0];
    end

    always_ff @(posedge i_dclk or posedge i_clr) begin
        if (i_clr) begin
            r_up_sync <= 2'b00;
            r_dn_sync <= 2'b00;
            r_pos     <= POS_RST;
        end else begin
            r_up_sync <= {r_up_sync[0], i_up};
            r_dn_sync <= {r_dn_sync[0], i_dn};
            if (i_load)
                r_pos <= POS_RST;
            else if (i_tick && i_en)
                r_pos <= w_next;
        end
    end

    assign o_pos = r_pos;
endmodule

// File: rtl/pong_game_engine.sv
// Pong game-state producer: frame tick, serve/play/point/over sequencing,
// ball motion with wall, paddle and goal handling, and score segment drive.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int FRAME_CYCLES = 416800,
    parameter int BALL_SPEED   = 2,
    parameter int PAD_SPEED    = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       l_up,
    input  logic       l_dn,
    input  logic       r_up,
    input  logic       r_dn,
    input  logic       start,
    output logic [9:0] ballx,
    output logic [9:0] bally,
    output logic [9:0] l_pos,
    output logic [9:0] r_pos,
    output logic [6:0] score_l,
    output logic [6:0] score_r,
    output dbg_t       o_dbg
);
    localparam int               CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int               SRV_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_FRAMES - 1);
    localparam logic [SRV_W-1:0] SRV_ONE  = SRV_W'(1);
    localparam coord_t           STEP     = coord_t'(BALL_SPEED);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
    localparam logic [9:0]       CX       = CENTRE_X[9:0];
    localparam logic [9:0]       CY       = CENTRE_Y[9:0];

    logic [CNT_W-1:0] r_frame_cnt;
    logic [2:0]       r_start_sync;
    state_t           r_state, w_state_next;
    logic [9:0]       r_ballx, w_ballx_next, r_bally, w_bally_next;
    logic             r_dx, w_dx_next, r_dy, w_dy_next;
    logic [3:0]       r_score_l, w_score_l_next, r_score_r, w_score_r_next;
    logic [6:0]       r_seg_l, r_seg_r;
    logic [SRV_W-1:0] r_serve_cnt, w_serve_next;
    logic             r_point_l, w_point_l_next;
    logic             w_tick, w_start_edge, w_load, w_pad_en;
    logic [9:0]       w_l_pos, w_r_pos;
    coord_t           w_nx, w_ny, w_nx_b, w_ny_b, w_lpos, w_rpos;
    logic             w_dx_b, w_dy_b, w_goal_l, w_goal_r;

    assign w_tick       = (r_frame_cnt == '0);
    assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
    assign w_pad_en     = (r_state != ST_IDLE) && (r_state != ST_OVER);

    pong_paddle #(.PAD_SPEED(PAD_SPEED)) u_lpad (
        .i_dclk(dclk), .i_clr(clr), .i_up(l_up), .i_dn(l_dn), .i_tick(w_tick),
        .i_en(w_pad_en), .i_load(w_load), .o_pos(w_l_pos)
    );

    pong_paddle #(.PAD_SPEED(PAD_SPEED)) u_rpad (
        .i_dclk(dclk), .i_clr(clr), .i_up(r_up), .i_dn(r_dn), .i_tick(w_tick),
        .i_en(w_pad_en), .i_load(w_load), .o_pos(w_r_pos)
    );

    assign w_lpos = coord_t'({1'b0, w_l_pos});
    assign w_rpos = coord_t'({1'b0, w_r_pos});
    assign w_nx   = coord_t'({1'b0, r_ballx}) + (r_dx ? STEP : -STEP);
    assign w_ny   = coord_t'({1'b0, r_bally}) + (r_dy ? STEP : -STEP);

    // Wall first, then paddles see the wall-corrected row
    always_comb begin
        w_ny_b = w_ny;
        w_dy_b = r_dy;
        if (w_ny <= Y_MIN) begin
            w_ny_b = Y_MIN;
            w_dy_b = 1'b1;
        end else if (w_ny >= Y_MAX) begin
            w_ny_b = Y_MAX;
            w_dy_b = 1'b0;
        end
        w_nx_b = w_nx;
        w_dx_b = r_dx;
        if (!r_dx && (w_nx <= LPAD_X) && (w_ny_b + BALL_BOT >= w_lpos) &&
            (w_ny_b - BALL_TOP <= w_lpos + PAD_SPAN)) begin
            w_nx_b = LPAD_X;
            w_dx_b = 1'b1;
        end else if (r_dx && (w_nx >= RPAD_X) && (w_ny_b + BALL_BOT >= w_rpos) &&
                     (w_ny_b - BALL_TOP <= w_rpos + PAD_SPAN)) begin
            w_nx_b = RPAD_X;
            w_dx_b = 1'b0;
        end
    end

    assign w_goal_r = (w_nx_b <= GOAL_L);
    assign w_goal_l = (w_nx_b >= GOAL_R);

    always_comb begin
        w_state_next   = r_state;
        w_ballx_next   = r_ballx;
        w_bally_next   = r_bally;
        w_dx_next      = r_dx;
        w_dy_next      = r_dy;
        w_score_l_next = r_score_l;
        w_score_r_next = r_score_r;
        w_serve_next   = r_serve_cnt;
        w_point_l_next = r_point_l;
        w_load         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ballx_next   = CX;
                w_bally_next   = CY;
                w_score_l_next = 4'd0;
                w_score_r_next = 4'd0;
                if (w_start_edge) begin
                    w_dx_next    = 1'b1;
                    w_dy_next    = 1'b1;
                    w_serve_next = '0;
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                w_ballx_next = CX;
                w_bally_next = CY;
                if (w_tick) begin
                    if (r_serve_cnt == SRV_LAST) begin
                        w_serve_next = '0;
                        w_state_next = ST_PLAY;
                    end else begin
                        w_serve_next = r_serve_cnt + SRV_ONE;
                    end
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (w_goal_r || w_goal_l) begin
                        // Recentre on the goal tick; the bounce results are discarded
                        w_ballx_next   = CX;
                        w_bally_next   = CY;
                        w_point_l_next = w_goal_l;
                        w_state_next   = ST_POINT;
                        if (w_goal_l)
                            w_score_l_next = r_score_l + 4'd1;
                        else
                            w_score_r_next = r_score_r + 4'd1;
                    end else begin
                        w_ballx_next = w_nx_b[9:0];
                        w_bally_next = w_ny_b[9:0];
                        w_dx_next    = w_dx_b;
                        w_dy_next    = w_dy_b;
                    end
                end
            end
            ST_POINT: begin
                w_ballx_next = CX;
                w_bally_next = CY;
                w_dx_next    = r_point_l;
                w_dy_next    = ~r_dy;
                w_serve_next = '0;
                if ((r_point_l ? r_score_l : r_score_r) == WIN)
                    w_state_next = ST_OVER;
                else
                    w_state_next = ST_SERVE;
            end
            ST_OVER: begin
                w_ballx_next = CX;
                w_bally_next = CY;
                if (w_start_edge) begin
                    w_score_l_next = 4'd0;
                    w_score_r_next = 4'd0;
                    w_load         = 1'b1;
                    w_serve_next   = '0;
                    w_state_next   = ST_SERVE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            r_frame_cnt  <= '0;
            r_start_sync <= 3'b000;
            r_ballx      <= CX;
            r_bally      <= CY;
            r_dx         <= 1'b1;
            r_dy         <= 1'b1;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_seg_l      <= 7'h3F;
            r_seg_r      <= 7'h3F;
            r_serve_cnt  <= '0;
            r_point_l    <= 1'b0;
        end else begin
            r_frame_cnt  <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + CNT_ONE;
            r_start_sync <= {r_start_sync[1:0], start};
            r_ballx      <= w_ballx_next;
            r_bally      <= w_bally_next;
            r_dx         <= w_dx_next;
            r_dy         <= w_dy_next;
            r_score_l    <= w_score_l_next;
            r_score_r    <= w_score_r_next;
            r_seg_l      <= seg7_decode(r_score_l);
            r_seg_r      <= seg7_decode(r_score_r);
            r_serve_cnt  <= w_serve_next;
            r_point_l    <= w_point_l_next;
        end
    end

    assign ballx        = r_ballx;
    assign bally        = r_bally;
    assign l_pos        = w_l_pos;
    assign r_pos        = w_r_pos;
    assign score_l      = r_seg_l;
    assign score_r      = r_seg_r;
    assign o_dbg.state  = r_state;
    assign o_dbg.dx_pos = r_dx;
    assign o_dbg.dy_pos = r_dy;
endmodule

// File: tb/tb_pong_game_engine.sv
// Self-checking bench for pong_game_engine: frame-level game model compared
// every tick, directed serve/bounce/goal/win sequences and a randomized rally.
module tb_pong_game_engine;
    import pong_pkg::*;

    localparam int FC  = 16;
    localparam int BS  = 2;
    localparam int PS  = 4;
    localparam int SF  = 60;
    localparam int WIN = 2;

    localparam logic [6:0] SEG_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       dclk = 1'b0;
    logic       clr  = 1'b1;
    logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0, start = 1'b0;
    logic [9:0] ballx, bally, l_pos, r_pos;
    logic [6:0] score_l, score_r;
    dbg_t       o_dbg;

    pong_game_engine #(
        .FRAME_CYCLES(FC), .BALL_SPEED(BS), .PAD_SPEED(PS),
        .SERVE_FRAMES(SF), .WIN_SCORE(WIN)
    ) dut (
        .dclk(dclk), .clr(clr), .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
        .start(start), .ballx(ballx), .bally(bally), .l_pos(l_pos), .r_pos(r_pos),
        .score_l(score_l), .score_r(score_r), .o_dbg(o_dbg)
    );

    always #5 dclk = ~dclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Frame-level game model: one call per tick, POINT folded into the goal
    int     m_bx, m_by, m_dx, m_dy, m_lp, m_rp, m_sl, m_sr, m_cnt;
    state_t m_st;
    bit     m_goal;
    bit     rand_mode = 1'b0;
    logic   nx_lu = 1'b0, nx_ld = 1'b0, nx_ru = 1'b0, nx_rd = 1'b0;

    task automatic m_reset();
        m_bx = 464; m_by = 271; m_dx = 1; m_dy = 1;
        m_lp = 221; m_rp = 221; m_sl = 0; m_sr = 0; m_cnt = 0;
        m_st = ST_IDLE; m_goal = 1'b0;
    endtask

    function automatic int pad_move(input int p, input logic up, input logic dn);
        int q;
        q = p;
        if (up && !dn) q = q - PS;
        else if (dn && !up) q = q + PS;
        if (q < 81) q = 81;
        if (q > 361) q = 361;
        return q;
    endfunction

    task automatic m_tick();
        int nx, ny, ndx, ndy;
        bit pad_en;
        m_goal = 1'b0;
        pad_en = (m_st != ST_IDLE) && (m_st != ST_OVER);
        if (m_st == ST_SERVE) begin
            m_cnt++;
            if (m_cnt == SF) m_st = ST_PLAY;
        end else if (m_st == ST_PLAY) begin
            nx = m_bx + m_dx * BS;
            ny = m_by + m_dy * BS;
            ndx = m_dx;
            ndy = m_dy;
            if (ny <= 85) begin ny = 85; ndy = 1; end
            else if (ny >= 455) begin ny = 455; ndy = -1; end
            if (m_dx < 0 && nx <= 218 && ny + 5 >= m_lp && ny - 4 <= m_lp + 99) begin
                nx = 218; ndx = 1;
            end
            if (m_dx > 0 && nx >= 713 && ny + 5 >= m_rp && ny - 4 <= m_rp + 99) begin
                nx = 713; ndx = -1;
            end
            if (nx <= 198 || nx >= 729) begin
                m_goal = 1'b1;
                if (nx <= 198) begin m_sr++; ndx = -1; end
                else begin m_sl++; ndx = 1; end
                ndy = -m_dy;
                nx = 464;
                ny = 271;
                m_cnt = 0;
                m_st = (m_sl == WIN || m_sr == WIN) ? ST_OVER : ST_SERVE;
            end
            m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
        end
        if (pad_en) begin
            m_lp = pad_move(m_lp, l_up, l_dn);
            m_rp = pad_move(m_rp, r_up, r_dn);
        end
    endtask

    task automatic m_press();
        if (m_st == ST_IDLE) begin
            m_st = ST_SERVE; m_dx = 1; m_dy = 1; m_cnt = 0;
        end else if (m_st == ST_OVER) begin
            m_st = ST_SERVE; m_sl = 0; m_sr = 0; m_lp = 221; m_rp = 221; m_cnt = 0;
        end
    endtask

    task automatic pick_buttons();
        if ($urandom_range(0, 3) == 0) begin
            l_up = 1'($urandom_range(0, 1)); l_dn = 1'($urandom_range(0, 1));
        end else begin
            l_up = (m_by < m_lp + 40); l_dn = (m_by > m_lp + 60);
        end
        if ($urandom_range(0, 3) == 0) begin
            r_up = 1'($urandom_range(0, 1)); r_dn = 1'($urandom_range(0, 1));
        end else begin
            r_up = (m_by < m_rp + 40); r_dn = (m_by > m_rp + 60);
        end
    endtask

    function automatic bit rand_start();
        if (m_st == ST_OVER || m_st == ST_IDLE) return ($urandom_range(0, 3) == 0);
        return ($urandom_range(0, 49) == 0);
    endfunction

    // Entered on the negedge just before a tick edge; leaves at the same phase
    task automatic run_frame(input bit want_start);
        int k;
        @(posedge dclk);
        m_tick();
        @(negedge dclk);
        check("ballx", ballx, m_bx);
        check("bally", bally, m_by);
        check("l_pos", l_pos, m_lp);
        check("r_pos", r_pos, m_rp);
        if (m_goal) check("point_state", 32'(o_dbg.state), 32'(ST_POINT));
        @(negedge dclk);
        check("state", 32'(o_dbg.state), 32'(m_st));
        check("dx", o_dbg.dx_pos, (m_dx > 0));
        check("dy", o_dbg.dy_pos, (m_dy > 0));
        check("score_l", score_l, SEG_TAB[m_sl]);
        check("score_r", score_r, SEG_TAB[m_sr]);
        if (rand_mode) pick_buttons();
        else begin l_up = nx_lu; l_dn = nx_ld; r_up = nx_ru; r_dn = nx_rd; end
        k = 1;
        if (want_start) begin
            start = 1'b1;
            repeat (3) @(negedge dclk);
            start = 1'b0;
            k += 3;
            m_press();
        end
        repeat (FC - 1 - k) @(negedge dclk);
    endtask

    typedef struct {
        logic [3:0] digit;
        logic [6:0] seg;
    } seg_vec_t;

    seg_vec_t vecs [10];

    initial begin
        for (int i = 0; i < 10; i++) begin
            vecs[i].digit = 4'(i);
            vecs[i].seg   = SEG_TAB[i];
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("seg7_decode_%0d", i), seg7_decode(vecs[i].digit), vecs[i].seg);

        repeat (3) @(negedge dclk);
        check("rst_ballx", ballx, 464);
        check("rst_bally", bally, 271);
        check("rst_l_pos", l_pos, 221);
        check("rst_r_pos", r_pos, 221);
        check("rst_score_l", score_l, 7'h3F);
        check("rst_score_r", score_r, 7'h3F);
        check("rst_state", 32'(o_dbg.state), 32'(ST_IDLE));
        clr = 1'b0;
        m_reset();

        repeat (3) run_frame(1'b0);
        check("idle_ballx", ballx, 464);
        check("idle_bally", bally, 271);
        check("idle_l_pos", l_pos, 221);
        check("idle_score_l", score_l, 7'h3F);

        run_frame(1'b1);
        repeat (SF) run_frame(1'b0);
        check("serve_to_play", 32'(o_dbg.state), 32'(ST_PLAY));
        repeat (2) run_frame(1'b0);
        check("play2_ballx", ballx, 468);
        check("play2_bally", bally, 275);

        // Left paddle pinned up, right paddle with both buttons held
        nx_lu = 1'b1; nx_ru = 1'b1; nx_rd = 1'b1;
        for (int f = 0; f < 1000 && m_st != ST_OVER; f++) run_frame(1'b0);
        check("game_over", 32'(o_dbg.state), 32'(ST_OVER));
        check("win_score_l", score_l, 7'h5B);
        check("win_score_r", score_r, 7'h3F);
        check("lpad_clamp", l_pos, 81);
        check("rpad_both", r_pos, 221);

        nx_lu = 1'b0; nx_ru = 1'b0; nx_rd = 1'b0;
        repeat (2) run_frame(1'b0);
        check("over_ballx", ballx, 464);
        check("over_bally", bally, 271);
        run_frame(1'b1);
        check("restart_score_l", score_l, 7'h3F);
        check("restart_l_pos", l_pos, 221);
        check("restart_state", 32'(o_dbg.state), 32'(ST_SERVE));

        rand_mode = 1'b1;
        for (int f = 0; f < 900; f++) run_frame(rand_start());
        for (int f = 0; f < 300 && !(m_st == ST_PLAY && m_bx != 464); f++)
            run_frame(rand_start());

        clr = 1'b1;
        l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
        #1;
        check("clr_ballx", ballx, 464);
        check("clr_bally", bally, 271);
        check("clr_l_pos", l_pos, 221);
        check("clr_r_pos", r_pos, 221);
        check("clr_score_l", score_l, 7'h3F);
        check("clr_score_r", score_r, 7'h3F);
        check("clr_state", 32'(o_dbg.state), 32'(ST_IDLE));
        @(negedge dclk);
        @(negedge dclk);
        clr = 1'b0;
        rand_mode = 1'b0;
        m_reset();
        repeat (2) run_frame(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
